// File: rtl/ieee754_addsub_pipe.sv
// Floating-point add/subtract: input register followed by three pipeline stages.
// Subnormals flush to zero, rounding is nearest-even, output uses valid/ready.
module ieee754_addsub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   localparam int XLEN = 1 + EXP_W + MAN_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic [3:0]      flags
);
   localparam int MW = MAN_W + 1;
   localparam int GW = MAN_W + 4;
   localparam int SW = MAN_W + 5;
   localparam int EW = EXP_W + 2;
   localparam logic [EXP_W-1:0] EMAX = '1;
   localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(MAN_W + 3);
   localparam logic [XLEN-1:0] QNAN =
      {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

   function automatic logic [EW-1:0] lzc(input logic [GW-1:0] v);
      logic [EW-1:0] n;
      n = EW'(GW);
      for (int i = 0; i < GW; i++)
         if (v[i]) n = EW'(GW - 1 - i);
      return n;
   endfunction

   logic v0_q, v1_q, v2_q, v3_q;
   logic stall;

   assign stall    = v3_q & ~out_ready;
   assign in_ready = ~stall;

   logic            op0_q;
   logic [XLEN-1:0] a0_q, b0_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q  <= 1'b0;
         op0_q <= 1'b0;
         a0_q  <= '0;
         b0_q  <= '0;
      end else if (!stall) begin
         v0_q <= in_valid;
         if (in_valid) begin
            a0_q  <= A;
            b0_q  <= B;
            op0_q <= op;
         end
      end
   end

   logic             sa, sb;
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_nan, b_nan, a_inf, b_inf, a_z, b_z, swap;
   logic [MW-1:0]    ma, mb;

   assign sa    = a0_q[XLEN-1];
   assign sb    = b0_q[XLEN-1] ^ op0_q;
   assign ea    = a0_q[XLEN-2:MAN_W];
   assign eb    = b0_q[XLEN-2:MAN_W];
   assign fa    = a0_q[MAN_W-1:0];
   assign fb    = b0_q[MAN_W-1:0];
   assign a_nan = (ea == EMAX) && (fa != '0);
   assign b_nan = (eb == EMAX) && (fb != '0);
   assign a_inf = (ea == EMAX) && (fa == '0);
   assign b_inf = (eb == EMAX) && (fb == '0);
   assign a_z   = (ea == '0);
   assign b_z   = (eb == '0);
   assign ma    = a_z ? '0 : {1'b1, fa};
   assign mb    = b_z ? '0 : {1'b1, fb};
   assign swap  = {eb, mb} > {ea, ma};

   logic             sx1_d, sub1_d, spec1_d;
   logic [EXP_W-1:0] ex1_d, ed1_d;
   logic [MW-1:0]    mx1_d, my1_d;
   logic [XLEN-1:0]  sres1_d;
   logic [3:0]       sflg1_d;

   always_comb begin
      sx1_d   = swap ? sb : sa;
      sub1_d  = sa ^ sb;
      ex1_d   = swap ? eb : ea;
      ed1_d   = swap ? eb - ea : ea - eb;
      mx1_d   = swap ? mb : ma;
      my1_d   = swap ? ma : mb;
      spec1_d = 1'b0;
      sres1_d = '0;
      sflg1_d = '0;
      if (a_nan | b_nan | (a_inf & b_inf & sub1_d)) begin
         spec1_d = 1'b1;
         sres1_d = QNAN;
         sflg1_d = 4'b1000;
      end else if (a_inf) begin
         spec1_d = 1'b1;
         sres1_d = {sa, EMAX, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec1_d = 1'b1;
         sres1_d = {sb, EMAX, {MAN_W{1'b0}}};
      end
   end

   logic             sx1_q, sub1_q, spec1_q;
   logic [EXP_W-1:0] ex1_q, ed1_q;
   logic [MW-1:0]    mx1_q, my1_q;
   logic [XLEN-1:0]  sres1_q;
   logic [3:0]       sflg1_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q    <= 1'b0;
         sx1_q   <= 1'b0;
         sub1_q  <= 1'b0;
         spec1_q <= 1'b0;
         ex1_q   <= '0;
         ed1_q   <= '0;
         mx1_q   <= '0;
         my1_q   <= '0;
         sres1_q <= '0;
         sflg1_q <= '0;
      end else if (!stall) begin
         v1_q <= v0_q;
         if (v0_q) begin
            sx1_q   <= sx1_d;
            sub1_q  <= sub1_d;
            spec1_q <= spec1_d;
            ex1_q   <= ex1_d;
            ed1_q   <= ed1_d;
            mx1_q   <= mx1_d;
            my1_q   <= my1_d;
            sres1_q <= sres1_d;
            sflg1_q <= sflg1_d;
         end
      end
   end

   logic [GW-1:0] yext, ymask, yal_d;
   logic [SW-1:0] sum2_d;

   // Bits shifted past the guard position collapse into the sticky LSB.
   always_comb begin
      yext  = {my1_q, 3'b000};
      ymask = (GW'(1) << ed1_q) - GW'(1);
      if (ed1_q >= SH_MAX) begin
         yal_d = {{(GW-1){1'b0}}, |my1_q};
      end else begin
         yal_d    = yext >> ed1_q;
         yal_d[0] = yal_d[0] | (|(yext & ymask));
      end
      if (sub1_q)
         sum2_d = {1'b0, mx1_q, 3'b000} - {1'b0, yal_d};
      else
         sum2_d = {1'b0, mx1_q, 3'b000} + {1'b0, yal_d};
   end

   logic             s2_q, zs2_q, spec2_q;
   logic [EXP_W-1:0] e2_q;
   logic [SW-1:0]    sum2_q;
   logic [XLEN-1:0]  sres2_q;
   logic [3:0]       sflg2_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2_q    <= 1'b0;
         s2_q    <= 1'b0;
         zs2_q   <= 1'b0;
         spec2_q <= 1'b0;
         e2_q    <= '0;
         sum2_q  <= '0;
         sres2_q <= '0;
         sflg2_q <= '0;
      end else if (!stall) begin
         v2_q <= v1_q;
         if (v1_q) begin
            s2_q    <= sx1_q;
            zs2_q   <= sx1_q & ~sub1_q;
            spec2_q <= spec1_q;
            e2_q    <= ex1_q;
            sum2_q  <= sum2_d;
            sres2_q <= sres1_q;
            sflg2_q <= sflg1_q;
         end
      end
   end

   logic [EW-1:0]    lz, en, er;
   logic [GW-1:0]    nrm;
   logic [MAN_W+1:0] rnd;
   logic [MAN_W-1:0] frac;
   logic             g, r, st, up;
   logic [XLEN-1:0]  res_d;
   logic [3:0]       flg_d;

   always_comb begin
      lz = lzc(sum2_q[GW-1:0]);
      if (sum2_q[SW-1]) begin
         nrm = {sum2_q[SW-1:2], |sum2_q[1:0]};
         en  = {2'b00, e2_q} + EW'(1);
      end else begin
         nrm = sum2_q[GW-1:0] << lz;
         en  = {2'b00, e2_q} - lz;
      end
      g    = nrm[2];
      r    = nrm[1];
      st   = nrm[0];
      up   = g & (r | st | nrm[3]);
      rnd  = {1'b0, nrm[GW-1:3]} + {{(MAN_W+1){1'b0}}, up};
      er   = en;
      frac = rnd[MAN_W-1:0];
      if (rnd[MAN_W+1]) begin
         er   = en + EW'(1);
         frac = rnd[MAN_W:1];
      end
      res_d = '0;
      flg_d = '0;
      if (spec2_q) begin
         res_d = sres2_q;
         flg_d = sflg2_q;
      end else if (sum2_q == '0) begin
         res_d = {zs2_q, {(XLEN-1){1'b0}}};
      end else if (en[EW-1] || en == '0) begin
         res_d = {s2_q, {(XLEN-1){1'b0}}};
         flg_d = 4'b0011;
      end else if (er >= {2'b00, EMAX}) begin
         res_d = {s2_q, EMAX, {MAN_W{1'b0}}};
         flg_d = 4'b0101;
      end else begin
         res_d = {s2_q, er[EXP_W-1:0], frac};
         flg_d = {3'b000, g | r | st};
      end
   end

   logic [XLEN-1:0] res_q;
   logic [3:0]      flg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3_q  <= 1'b0;
         res_q <= '0;
         flg_q <= '0;
      end else if (!stall) begin
         v3_q <= v2_q;
         if (v2_q) begin
            res_q <= res_d;
            flg_q <= flg_d;
         end
      end
   end

   assign out_valid = v3_q;
   assign result    = res_q;
   assign flags     = flg_q;

endmodule

// File: tb/tb_ieee754_addsub_pipe.sv
// Scoreboard bench for ieee754_addsub_pipe (single precision).
// Expected results are queued at acceptance and popped at output.
module tb_ieee754_addsub_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        op = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic [3:0]  flags;

   logic [35:0] exp_d = '0;
   logic [35:0] sb_q[$];
   logic [31:0] tbl[0:10];
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ieee754_addsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .A(A),
      .B(B),
      .op(op),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .flags(flags)
   );

   task automatic check(input string tag, input logic [35:0] got,
                        input logic [35:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) sb_q.push_back(exp_d);
      if (rst_n && out_valid && out_ready) begin
         if (sb_q.size() == 0)
            check("unexp_out", {35'd0, out_valid}, 36'd0);
         else
            check("sb", {result, flags}, sb_q.pop_front());
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] r,
                       input logic [3:0] f);
      bit ok;
      A = a;
      B = b;
      op = o;
      exp_d = {r, f};
      in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!ok) check("send_timeout", 36'd0, 36'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && sb_q.size() != 0; t++) begin
         @(posedge clk);
         #1;
      end
      check("drain", 36'(sb_q.size()), 36'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int acc;
      int idx;
      bit took;
      bit seen;
      tbl[0] = 32'h00000000; tbl[1] = 32'h3F800000;
      tbl[2] = 32'h40000000; tbl[3] = 32'h40400000;
      tbl[4] = 32'h40800000; tbl[5] = 32'h40A00000;
      tbl[6] = 32'h40C00000; tbl[7] = 32'h40E00000;
      tbl[8] = 32'h41000000; tbl[9] = 32'h41100000;
      tbl[10] = 32'h41200000;

      #1;
      check("rst_state", {out_valid, in_ready, result, flags[1:0]},
            {1'b0, 1'b1, 32'h0, 2'b00});
      check("rst_flags", {32'h0, flags}, 36'h0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
      n = 0;
      while (!out_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("latency", 36'(n), 36'd3);
      drain();

      send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
      send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
      send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000);
      send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
      send(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
      send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
      send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000);
      send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
      send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
      send(32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000);
      send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);
      send(32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
      send(32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000);
      drain();

      out_ready = 1'b0;
      acc = 0;
      idx = 0;
      for (int c = 0; c < 60 && idx < 8; c++) begin
         A = tbl[1];
         B = tbl[idx+1];
         op = 1'b0;
         exp_d = {tbl[idx+2], 4'b0000};
         in_valid = 1'b1;
         @(negedge clk);
         took = in_ready;
         if (took) acc++;
         if (c == 5) begin
            check("stall_accepts", 36'(acc), 36'd4);
            check("stall_ready", {35'd0, in_ready}, 36'd0);
            check("stall_hold", {result, flags}, {tbl[2], 4'b0000});
         end
         @(posedge clk);
         #1;
         if (took) idx++;
         if (c == 5) out_ready = 1'b1;
      end
      in_valid = 1'b0;
      drain();

      for (int k = 0; k < 3; k++) begin
         A = tbl[1];
         B = tbl[k+1];
         op = 1'b0;
         exp_d = {tbl[k+2], 4'b0000};
         in_valid = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_out", {out_valid, in_ready, result, flags[1:0]},
            {1'b0, 1'b1, 32'h0, 2'b00});
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 6; t++) begin
         @(negedge clk);
         seen = seen | out_valid;
      end
      check("no_stale", {35'd0, seen}, 36'd0);
      @(posedge clk);
      #1;
      send(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ieee754_addsub_pipe.md
IEEE754_ADDSUB_PIPE -- requirements
Module: ieee754_addsub_pipe

Interface
REQ-001 The module SHALL have parameter EXP_W, default 8, meaning exponent field width.
REQ-002 The module SHALL have parameter MAN_W, default 23, meaning stored mantissa field width.
REQ-003 The module SHALL have localparam XLEN = 1+EXP_W+MAN_W, meaning operand and result width.
REQ-004 The module SHALL have port clk, input, 1, the single clock; all state is rising-edge clocked.
REQ-005 The module SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-006 The module SHALL have port in_valid, input, 1, meaning the operands are presented.
REQ-007 The module SHALL have port in_ready, output, 1, meaning operands are accepted this cycle.
REQ-008 The module SHALL have ports A and B, input, XLEN each, meaning the operands.
REQ-009 The module SHALL have port op, input, 1, meaning 0 = A+B and 1 = A-B.
REQ-010 The module SHALL have port out_valid, output, 1, meaning result and flags are valid.
REQ-011 The module SHALL have port out_ready, input, 1, meaning the consumer accepts the result.
REQ-012 The module SHALL have port result, output, XLEN, meaning the sum or difference.
REQ-013 The module SHALL have port flags, output, 4, as {invalid, overflow, underflow, inexact}.

Function
REQ-014 Pipeline SHALL be three registered stages:
- S1: unpack, sign flip of B when op=1, special-case detect, magnitude swap so |X|>=|Y|, exponent difference.
- S2: align Y with guard/round/sticky (shift >= MAN_W+3 leaves only sticky), then add or subtract the mantissas.
- S3: normalise (carry right-shift or leading-zero left-shift), round-to-nearest-even, pack, flags.
REQ-015 An operand pair SHALL be accepted when in_valid && in_ready.
REQ-016 The result for an accepted pair SHALL appear with out_valid=1 exactly 3 cycles later when out_ready stays high.
REQ-017 Throughput SHALL be one result per cycle when out_ready stays high.
REQ-018 stall = out_valid && !out_ready; in_ready = !stall (combinational); all stage registers SHALL hold while stall=1.
REQ-019 While out_valid=1 and out_ready=0, result and flags SHALL be held stable.
REQ-020 Results SHALL leave in acceptance order, with no loss and no duplication.
REQ-021 Subnormal inputs SHALL be flushed to zero of the same sign.
REQ-022 A subnormal or underflowing result SHALL be flushed to signed zero with underflow=1 and inexact=1.
REQ-023 Any NaN input, or inf minus inf of equal magnitude, SHALL give canonical qNaN {0, all-ones exponent, 1, zeros} with invalid=1.
REQ-024 inf op finite SHALL give the inf operand with all flags 0.
REQ-025 Rounded exponent reaching all-ones SHALL give signed inf with overflow=1 and inexact=1.
REQ-026 An exact zero from cancellation SHALL give +0.
REQ-027 (-0)+(-0) SHALL give -0.
REQ-028 Rounding SHALL be RNE: round up if G && (R || S || lsb).
REQ-029 Mantissa carry out of rounding SHALL increment the exponent.
REQ-030 inexact SHALL be set if G, R or S is nonzero.
REQ-031 Result sign SHALL be the sign of the larger-magnitude operand (after op flip).

Reset
REQ-032 On rst_n=0, all stage valid bits SHALL clear immediately, including mid-operation; in-flight operations are discarded.
REQ-033 During and after reset: out_valid=0, result=0, flags=0, in_ready=1.
REQ-034 First acceptance SHALL be possible on the first clock edge after rst_n rises.

Verification (EXP_W=8, MAN_W=23)
REQ-035 Bench SHALL check: A=0x3F800000, B=0x40000000, op=0 -> result 0x40400000, flags 0000, out_valid 3 cycles after accept.
REQ-036 Bench SHALL check: A=0x3F800000, B=0x3F800000, op=1 -> 0x00000000, flags 0000; A=0x80000000 + B=0x80000000, op=0 -> 0x80000000.
REQ-037 Bench SHALL check:
- A=0x3F800000 + B=0x33800000 (tie) -> 0x3F800000, inexact=1.
- B=0x33800001 -> 0x3F800001, inexact=1.
REQ-038 Bench SHALL check:
- 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, flags 0101.
- 0x7F800000 - 0x7F800000 -> 0x7FC00000, flags 1000.
REQ-039 Bench SHALL check: out_ready=0 for 6 cycles while in_valid=1 streams 1.0+n -> in_ready drops after 4 accepts (3 in-flight + 1 held), no loss, in-order results on release.
REQ-040 Bench SHALL check: rst_n pulsed low with 3 operations in flight -> out_valid=0 at once, no stale result after release, next operation correct.
